// File: rtl/sm_debug_ctrl_if.sv
// Debug host <-> sm_debug_ctrl command/response channel.
// Both directions use a valid/ready handshake.
interface sm_debug_ctrl_if;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 32;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_arg;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sm_debug_ctrl.sv
// Run-control sequencer for schoolRISCV: gates the CPU clock-enable for halt/run/step,
// a PC breakpoint and a cycle watchdog, and serves register-file and counter reads.
module sm_debug_ctrl #(
    parameter int unsigned CNT_W        = 32,
    parameter bit          RUN_ON_RESET = 1'b1,
    parameter int unsigned WDOG_CYCLES  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    sm_debug_ctrl_if.slave   dbg,
    input  logic [31:0]      pc,
    output logic             cpu_en,
    output logic [4:0]       reg_addr,
    input  logic [31:0]      reg_data,
    output logic             halted,
    output logic             wdog_hit,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int unsigned STEP_W = 16;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_HALT     = 3'd1;
    localparam logic [2:0] OP_RUN      = 3'd2;
    localparam logic [2:0] OP_STEP     = 3'd3;
    localparam logic [2:0] OP_READ_REG = 3'd4;
    localparam logic [2:0] OP_SET_BP   = 3'd5;
    localparam logic [2:0] OP_CLR_BP   = 3'd6;
    localparam logic [2:0] OP_READ_CNT = 3'd7;

    localparam bit               WDOG_EN   = (WDOG_CYCLES != 0);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HALTED,
        S_RUNNING,
        S_STEPPING,
        S_RD_WAIT,
        S_RESP
    } state_t;

    localparam state_t RESET_STATE = RUN_ON_RESET ? S_RUNNING : S_HALTED;

    state_t            state;
    logic [STEP_W-1:0] stepLeft;
    logic              skip;
    logic              bpEn;
    logic [31:0]       bpAddr;
    logic              respRun;
    logic              rspValid;
    logic [31:0]       rspData;

    logic              runRules;
    logic              bpHit;
    logic              wdogFire;
    logic              stopRun;
    logic              cmdReady;
    logic              accept;
    logic [STEP_W-1:0] stepCount;

    // A READ_CNT taken while running keeps the CPU under run rules during the response.
    always_comb begin
        runRules  = (state == S_RUNNING) || ((state == S_RESP) && respRun);
        bpHit     = runRules && bpEn && (pc == bpAddr) && !skip;
        cpu_en    = (state == S_STEPPING) || (runRules && !bpHit);
        wdogFire  = WDOG_EN && runRules && cpu_en && (cycle_cnt == WDOG_LAST);
        stopRun   = bpHit || wdogFire;
        cmdReady  = (state == S_HALTED) || (state == S_RUNNING);
        accept    = dbg.cmd_valid && cmdReady;
        stepCount = (dbg.cmd_arg[STEP_W-1:0] == '0) ? STEP_W'(1) : dbg.cmd_arg[STEP_W-1:0];
    end

    assign dbg.cmd_ready = cmdReady;
    assign dbg.rsp_valid = rspValid;
    assign dbg.rsp_data  = rspData;
    assign halted        = (state == S_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_STATE;
            stepLeft  <= '0;
            skip      <= 1'b0;
            bpEn      <= 1'b0;
            bpAddr    <= '0;
            respRun   <= 1'b0;
            rspValid  <= 1'b0;
            rspData   <= '0;
            reg_addr  <= '0;
            wdog_hit  <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            if (cpu_en)
                cycle_cnt <= cycle_cnt + CNT_W'(1);

            // skip lets a resumed CPU execute the instruction sitting on the breakpoint
            if (accept && ((dbg.cmd_op == OP_RUN) || (dbg.cmd_op == OP_STEP)))
                skip <= 1'b1;
            else if (cpu_en)
                skip <= 1'b0;

            if (wdogFire)
                wdog_hit <= 1'b1;

            case (state)
                S_HALTED: ;
                S_RUNNING: begin
                    if (stopRun)
                        state <= S_HALTED;
                end
                S_STEPPING: begin
                    stepLeft <= stepLeft - STEP_W'(1);
                    if (stepLeft == STEP_W'(1))
                        state <= S_HALTED;
                end
                S_RD_WAIT: begin
                    rspData  <= reg_data;
                    rspValid <= 1'b1;
                    respRun  <= 1'b0;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    if (stopRun)
                        respRun <= 1'b0;
                    if (dbg.rsp_ready) begin
                        rspValid <= 1'b0;
                        state    <= (respRun && !stopRun) ? S_RUNNING : S_HALTED;
                    end
                end
                default: state <= RESET_STATE;
            endcase

            // Accepted commands override the breakpoint/watchdog stop where they move state.
            if (accept) begin
                case (dbg.cmd_op)
                    OP_NOP: ;
                    OP_HALT: state <= S_HALTED;
                    OP_RUN: begin
                        if (state == S_HALTED) begin
                            state    <= S_RUNNING;
                            wdog_hit <= 1'b0;
                        end
                    end
                    OP_STEP: begin
                        stepLeft <= stepCount;
                        state    <= S_STEPPING;
                    end
                    OP_READ_REG: begin
                        reg_addr <= dbg.cmd_arg[4:0];
                        state    <= S_RD_WAIT;
                    end
                    OP_SET_BP: begin
                        bpAddr <= dbg.cmd_arg;
                        bpEn   <= 1'b1;
                    end
                    OP_CLR_BP: bpEn <= 1'b0;
                    OP_READ_CNT: begin
                        rspData  <= 32'(cycle_cnt);
                        rspValid <= 1'b1;
                        respRun  <= (state == S_RUNNING) && !stopRun;
                        state    <= S_RESP;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sm_debug_ctrl.sv
// Bench for sm_debug_ctrl: directed run-control scenarios followed by random command traffic,
// checked cycle by cycle against a behavioural model and a response scoreboard.
module tb_sm_debug_ctrl;

    localparam int unsigned W = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic        cpu_en;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        halted;
    logic        wdog_hit;
    logic [31:0] cycle_cnt;
    bit          randRdy = 1'b0;

    int errors = 0;
    int checks = 0;

    sm_debug_ctrl_if dbg ();

    assign reg_data = 32'hA5A5_0000 | {27'd0, reg_addr};

    sm_debug_ctrl #(
        .CNT_W       (32),
        .RUN_ON_RESET(1'b1),
        .WDOG_CYCLES (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dbg      (dbg),
        .pc       (pc),
        .cpu_en   (cpu_en),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .halted   (halted),
        .wdog_hit (wdog_hit),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: "free" = CPU under free-run rules, "steps" = pending single steps,
    // a read in flight blocks commands until its response has been consumed.
    bit          mFree    = 1'b1;
    int          mSteps   = 0;
    bit          mRdPend  = 1'b0;
    bit          mRspOut  = 1'b0;
    bit          mBpOn    = 1'b0;
    logic [31:0] mBpPc    = '0;
    bit          mSkip    = 1'b0;
    logic [31:0] mCnt     = '0;
    bit          mWdog    = 1'b0;
    logic [4:0]  mRegAddr = '0;
    logic [31:0] mPc      = '0;
    logic [31:0] expQ[$];

    function automatic bit mHit();
        return mFree && (mSteps == 0) && mBpOn && (mPc == mBpPc) && !mSkip;
    endfunction

    function automatic bit mEn();
        return (mSteps != 0) || (mFree && !mHit());
    endfunction

    function automatic bit mReady();
        return !mRspOut && !mRdPend && (mSteps == 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit          en, hit, wfire, acc, oldFree, oldRsp, oldRd;
        logic [31:0] oldCnt;
        if (!rst_n) begin
            mFree = 1'b1; mSteps = 0; mRdPend = 1'b0; mRspOut = 1'b0;
            mBpOn = 1'b0; mBpPc = '0; mSkip = 1'b0; mCnt = '0; mWdog = 1'b0;
            mRegAddr = '0;
            expQ.delete();
        end else begin
            en      = mEn();
            hit     = mHit();
            acc     = dbg.cmd_valid && mReady();
            wfire   = mFree && en && (mCnt == 32'(W - 1));
            oldFree = mFree;
            oldRsp  = mRspOut;
            oldRd   = mRdPend;
            oldCnt  = mCnt;
            if (en) begin
                mCnt = mCnt + 32'd1;
                mPc  = mPc + 32'd4;
            end
            if (acc && (dbg.cmd_op == 3'd2 || dbg.cmd_op == 3'd3)) mSkip = 1'b1;
            else if (en) mSkip = 1'b0;
            if (wfire) mWdog = 1'b1;
            if (mSteps > 0) mSteps--;
            if (mFree && (hit || wfire)) mFree = 1'b0;
            if (oldRd) begin
                mRdPend = 1'b0;
                mRspOut = 1'b1;
            end
            if (oldRsp && dbg.rsp_ready) mRspOut = 1'b0;
            if (acc) begin
                case (dbg.cmd_op)
                    3'd1: mFree = 1'b0;
                    3'd2: if (!oldFree) begin mFree = 1'b1; mWdog = 1'b0; end
                    3'd3: begin
                        mSteps = (dbg.cmd_arg[15:0] == 16'd0) ? 1 : int'(dbg.cmd_arg[15:0]);
                        mFree  = 1'b0;
                    end
                    3'd4: begin
                        mRegAddr = dbg.cmd_arg[4:0];
                        mRdPend  = 1'b1;
                        mFree    = 1'b0;
                        expQ.push_back(32'hA5A5_0000 | {27'd0, dbg.cmd_arg[4:0]});
                    end
                    3'd5: begin mBpOn = 1'b1; mBpPc = dbg.cmd_arg; end
                    3'd6: mBpOn = 1'b0;
                    3'd7: begin
                        expQ.push_back(oldCnt);
                        mRspOut = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor: lockstep status checks and response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        check("cpu_en",    64'(cpu_en),        64'(mEn()));
        check("cmd_ready", 64'(dbg.cmd_ready), 64'(mReady()));
        check("halted",    64'(halted),        64'(mReady() && !mFree));
        check("wdog_hit",  64'(wdog_hit),      64'(mWdog));
        check("cycle_cnt", 64'(cycle_cnt),     64'(mCnt));
        check("reg_addr",  64'(reg_addr),      64'(mRegAddr));
        check("rsp_valid", 64'(dbg.rsp_valid), 64'(mRspOut));
        if (dbg.rsp_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got data %0h with no response outstanding at %0t",
                         dbg.rsp_data, $time);
            end else begin
                check("rsp_data", 64'(dbg.rsp_data), 64'(expQ[0]));
                if (dbg.rsp_ready) void'(expQ.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        pc = mPc;
        if (randRdy) dbg.rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] arg);
        bit acc = 1'b0;
        dbg.cmd_valid = 1'b1;
        dbg.cmd_op    = op;
        dbg.cmd_arg   = arg;
        for (int k = 0; k < 200 && !acc; k++) begin
            acc = dbg.cmd_ready;
            tick();
        end
        dbg.cmd_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout: op %0d still not accepted, required within 200 cycles", op);
        end
    endtask

    task automatic pulse_reset_checked();
        #2 rst_n = 1'b0;
        #1;
        check("rst_cycle_cnt", 64'(cycle_cnt),     64'd0);
        check("rst_halted",    64'(halted),        64'd0);
        check("rst_cpu_en",    64'(cpu_en),        64'd1);
        check("rst_wdog",      64'(wdog_hit),      64'd0);
        check("rst_rsp_valid", 64'(dbg.rsp_valid), 64'd0);
        check("rst_reg_addr",  64'(reg_addr),      64'd0);
        check("rst_cmd_ready", 64'(dbg.cmd_ready), 64'd1);
        #4 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench still running at %0t, required completion earlier", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] bp;
        int          r;
        dbg.cmd_valid = 1'b0;
        dbg.cmd_op    = '0;
        dbg.cmd_arg   = '0;
        dbg.rsp_ready = 1'b0;
        #17 rst_n = 1'b1;

        // Free run out of reset, then the watchdog stops it after exactly W enabled cycles.
        repeat (10) tick();
        check("run10_cnt",    64'(cycle_cnt),     64'd10);
        check("run10_halted", 64'(halted),        64'd0);
        check("run10_ready",  64'(dbg.cmd_ready), 64'd1);
        repeat (15) tick();
        check("wdog_cnt",    64'(cycle_cnt), 64'(W));
        check("wdog_halted", 64'(halted),    64'd1);
        check("wdog_flag",   64'(wdog_hit),  64'd1);
        send(3'd2, 32'd0);
        check("wdog_cleared", 64'(wdog_hit), 64'd0);
        check("run_resumed",  64'(halted),   64'd0);

        // Stepping: count 3, then count 0 behaves as 1.
        send(3'd1, 32'd0);
        send(3'd3, 32'd3);
        repeat (5) tick();
        check("step3_halted", 64'(halted), 64'd1);
        send(3'd3, 32'd0);
        repeat (3) tick();
        check("step0_halted", 64'(halted), 64'd1);

        // Breakpoint four instructions ahead, then resume through it.
        bp = mPc + 32'h10;
        send(3'd5, bp);
        send(3'd2, 32'd0);
        repeat (10) tick();
        check("bp_halted", 64'(halted), 64'd1);
        check("bp_cpu_en", 64'(cpu_en), 64'd0);
        send(3'd2, 32'd0);
        repeat (3) tick();
        check("bp_resumed", 64'(halted), 64'd0);
        send(3'd6, 32'd0);

        // Register read while running, response back-pressured for three cycles.
        dbg.rsp_ready = 1'b0;
        send(3'd4, 32'd11);
        repeat (3) tick();
        check("rr_valid",    64'(dbg.rsp_valid), 64'd1);
        check("rr_data",     64'(dbg.rsp_data),  64'hA5A5000B);
        check("rr_reg_addr", 64'(reg_addr),      64'd11);
        check("rr_cpu_en",   64'(cpu_en),        64'd0);
        dbg.rsp_ready = 1'b1;
        tick();
        dbg.rsp_ready = 1'b0;
        tick();
        check("rr_halted_after", 64'(halted), 64'd1);

        // Counter read while running keeps the CPU running.
        send(3'd2, 32'd0);
        repeat (7) tick();
        dbg.rsp_ready = 1'b1;
        send(3'd7, 32'd0);
        tick();
        check("rc_still_running", 64'(halted), 64'd0);
        dbg.rsp_ready = 1'b0;

        // Reset in the middle of a long step sequence.
        send(3'd3, 32'd40);
        repeat (3) tick();
        pulse_reset_checked();
        tick();

        // Random command traffic with random response back-pressure and occasional resets.
        randRdy = 1'b1;
        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 99));
            if      (r < 15) send(3'd1, $urandom());
            else if (r < 30) send(3'd2, $urandom());
            else if (r < 45) send(3'd3, {16'($urandom()), 16'($urandom_range(0, 5))});
            else if (r < 60) send(3'd4, $urandom());
            else if (r < 70) send(3'd5, mPc + 32'(4 * $urandom_range(0, 6)));
            else if (r < 75) send(3'd6, $urandom());
            else if (r < 88) send(3'd7, $urandom());
            else if (r < 95) send(3'd0, $urandom());
            else begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
            repeat ($urandom_range(0, 4)) tick();
        end

        randRdy = 1'b0;
        dbg.rsp_ready = 1'b1;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm_debug_ctrl.md
Name: sm_debug_ctrl

Overview:
Run-control and debug sequencer for the schoolRISCV core, placed in sm_top between a debug host (bench, UART bridge or JTAG shim) and sm_cpu. It drives the CPU clock-enable to implement halt, run, N-step, a single PC breakpoint and a cycle watchdog. It also owns and arbitrates the register-file debug read port (regAddr/regData). Commands and responses each use a valid/ready handshake.

Parameters:
CNT_W, 32, width of retired-cycle counter
RUN_ON_RESET, 1, 1: RUNNING after reset; 0: HALTED after reset
WDOG_CYCLES, 0, watchdog limit in enabled cycles; 0 disables the watchdog

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 READ_REG, 5 SET_BP, 6 CLR_BP, 7 READ_CNT
cmd_arg  in  32  STEP: [15:0] count; READ_REG: [4:0] reg; SET_BP: PC
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_data  out  32  response payload
pc  in  32  current CPU PC (sm_cpu fetch PC)
cpu_en  out  1  CPU clock enable
reg_addr  out  5  register-file debug read address
reg_data  in  32  register-file debug read data (combinational from reg_addr)
halted  out  1  1 in HALTED state
wdog_hit  out  1  sticky watchdog-expired flag
cycle_cnt  out  CNT_W  count of cycles with cpu_en=1

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state = RUNNING if RUN_ON_RESET else HALTED; cycle_cnt=0; bp_en=0; bp_addr=0; step_left=0; reg_addr=0; rsp_valid=0; rsp_data=0; wdog_hit=0; skip=0.
- States: HALTED, RUNNING, STEPPING, RD_WAIT, RESP.
- cmd_ready = 1 in HALTED and RUNNING only. A command is accepted on the edge where cmd_valid & cmd_ready.
- cpu_en (combinational):
  - RUNNING: 1 unless bp_hit, where bp_hit = bp_en & (pc==bp_addr) & ~skip.
  - STEPPING: 1.
  - Otherwise: 0.
- cycle_cnt increments on every edge with cpu_en=1 and wraps at 2^CNT_W.
- RUNNING, bp_hit=1: next state HALTED; the breakpointed instruction is not executed.
- skip is set when RUN or STEP is accepted. It clears after the first enabled cycle, so resuming from a breakpoint PC executes that instruction.
- HALT: accepted in RUNNING -> HALTED; cpu_en is 0 from the next cycle. HALT in HALTED is a no-op.
- RUN: HALTED -> RUNNING; clears wdog_hit. RUN in RUNNING is a no-op.
- STEP: step_left = count, with count 0 treated as 1. Next state STEPPING from HALTED or RUNNING.
  - Each STEPPING cycle decrements step_left.
  - At step_left==1 the next state is HALTED, giving exactly count enabled cycles.
  - Breakpoints are ignored while STEPPING.
- SET_BP: bp_addr=cmd_arg, bp_en=1. CLR_BP: bp_en=0. Neither changes state; both are valid in any accept state.
- READ_REG:
  - reg_addr = arg[4:0]; state -> RD_WAIT, which forces cpu_en=0 (implicit halt).
  - RD_WAIT lasts one cycle, then rsp_data = reg_data and state -> RESP.
  - A READ_REG issued while RUNNING leaves the CPU HALTED afterwards.
- READ_CNT: rsp_data = cycle_cnt zero-extended or truncated to 32 bits. State -> RESP directly, 1-cycle latency.
- RESP: rsp_valid=1 with rsp_data held stable until rsp_ready. On handshake, rsp_valid drops and state -> HALTED.
  - For READ_CNT issued while RUNNING, state returns to RUNNING.
  - cpu_en=0 during RESP for READ_REG; for READ_CNT-from-RUNNING, cpu_en stays governed by RUNNING rules.
- NOP: accepted, no effect.
- Watchdog (WDOG_CYCLES != 0): when cycle_cnt == WDOG_CYCLES-1 and cpu_en=1 in RUNNING, next state HALTED and wdog_hit=1. wdog_hit stays set until RUN. Not evaluated in STEPPING.
- Reset asserted mid-operation (any state): everything returns to reset values immediately; a pending response is dropped.

Test Plan:
- Reset with RUN_ON_RESET=1, run 10 cycles -> cpu_en=1 throughout, cycle_cnt=10, halted=0, cmd_ready=1.
- HALT, then STEP arg=3 -> cpu_en high for exactly 3 cycles, cycle_cnt +3, halted=1 after; STEP arg=0 -> exactly 1 cycle.
- SET_BP 0x10 then RUN, with pc stepping by 4 from 0 -> halt with pc=0x10 and cpu_en=0 at pc=0x10; RUN again -> executes 0x10, pc reaches 0x14 without re-halting.
- With reg_data = 0xA5A5_0000|reg_addr, READ_REG 11 while RUNNING, rsp_ready held low 3 cycles -> cpu_en=0 from the cycle after accept; reg_addr=11; rsp_data=0xA5A5000B stable while rsp_valid=1; halted=1 after handshake.
- READ_CNT after 7 enabled cycles -> rsp_data=7 one cycle after accept; CPU keeps running after handshake.
- WDOG_CYCLES=20, RUN from reset -> halt after exactly 20 enabled cycles, wdog_hit=1; RUN clears it. Reset asserted during STEPPING -> all outputs at reset values.
